fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage that drives the instruction memory read address and consumes its 32-bit read data. It holds the program counter and advances it by 4 per fetched word. It latches each fetched instruction with its PC into a one-entry output register. It hands entries to decode with a valid/ready handshake and supports a redirect (branch/jump) that flushes the output register.

Parameters:
ADDR_WIDTH, 6, word-address width of the instruction memory (depth 2**ADDR_WIDTH words)
RESET_PC, 32'h00000000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_WIDTH  word address to instruction memory, equals pc[ADDR_WIDTH+1:2]
imem_rd  input  32  instruction word from memory; combinational from imem_addr, same cycle
redirect  input  1  branch/jump taken; load redirect_pc, flush output
redirect_pc  input  32  new fetch byte address
out_valid  output  1  output register holds a valid instruction
out_ready  input  1  decode accepts the entry this cycle
out_instr  output  32  latched instruction
out_pc  output  32  byte address of out_instr
out_pc_plus4  output  32  out_pc + 4
fetch_count  output  32  number of completed handshakes (out_valid & out_ready) since reset

Behaviour:
- Reset, sampled on the clk edge:
  - pc <= RESET_PC
  - out_valid <= 0, out_instr <= 0, out_pc <= 0, out_pc_plus4 <= 0
  - fetch_count <= 0
  - Reset overrides redirect and the handshake.
- imem_addr is combinational from the pc register: pc[ADDR_WIDTH+1:2]. Upper PC bits are ignored, so addresses wrap modulo 4*2**ADDR_WIDTH bytes.
- load = !out_valid | out_ready (output register empty or being drained).
- Priority per cycle, when not in reset:
  1. redirect=1:
     - pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are forced to zero.
     - out_valid <= 0; out_instr/out_pc/out_pc_plus4 hold.
     - No fetch in this cycle; imem_rd is discarded.
     - A concurrent out_valid & out_ready still counts as a handshake (fetch_count increments).
  2. else if load:
     - out_instr <= imem_rd, out_pc <= pc, out_pc_plus4 <= pc + 4, out_valid <= 1.
     - pc <= pc + 4, with 32-bit wrap (32'hFFFFFFFC + 4 = 0).
  3. else (out_valid=1, out_ready=0): stall. pc, out_* and out_valid all hold. The instruction stays stable until accepted.
- Latency:
  - The first instruction after reset release appears with out_valid=1 one cycle after the first non-reset edge.
  - After a redirect, the target instruction appears with out_valid=1 two edges after the redirect cycle: one bubble, then the target word.
- Throughput: one instruction per cycle while out_ready=1 and there is no redirect.
- fetch_count increments by 1 on each edge where out_valid & out_ready, and wraps at 2**32.
- Outputs are registered except imem_addr. There is no combinational path from out_ready or redirect to any output.
- out_ready while out_valid=0 has no effect beyond allowing a load.

Test Plan:
- Reset sequencing:
  - Stimulus: reset=1 for 2 cycles, memory word i = 32'h1000_0000+i, then out_ready=1.
  - Required: out_valid=0 during reset; then out_pc=0/instr 32'h10000000, out_pc=4/instr 32'h10000001, out_pc=8/instr 32'h10000002 on consecutive cycles.
  - Required: imem_addr 0,1,2,3; out_pc_plus4 = out_pc+4.
- Backpressure:
  - Stimulus: with out_pc=8 valid, hold out_ready=0 for 3 cycles.
  - Required: out_pc=8 and out_instr stable for 3 cycles; imem_addr stays 3; fetch_count unchanged.
  - Required: when out_ready returns to 1, out_pc=12 follows with no skip and no duplicate.
- Redirect:
  - Stimulus: redirect=1 with redirect_pc=32'h40 while out_valid=1 and out_ready=0.
  - Required: next cycle out_valid=0 and imem_addr=16; following cycle out_pc=32'h40, instr=word 16.
- Misaligned redirect and wrap:
  - Stimulus: redirect_pc=32'h000000FE with ADDR_WIDTH=6.
  - Required: pc=32'hFC, imem_addr=63, then imem_addr=0 with out_pc=32'h100 (address wrap).
  - Stimulus: redirect_pc=32'hFFFFFFFC. Required: the next out_pc after it is 0.
- Redirect coinciding with handshake:
  - Stimulus: out_valid=1, out_ready=1, redirect=1 in the same cycle.
  - Required: fetch_count increments by 1, out_valid=0 next cycle, and no instruction from the old path is emitted.
- Reset mid-stream:
  - Stimulus: assert reset=1 during back-to-back fetch with fetch_count=5 and out_valid=1.
  - Required: next edge out_valid=0, fetch_count=0, imem_addr=0; fetch restarts at out_pc=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, reads the instruction
// memory combinationally, and presents each fetched word with its PC in a
// one-entry output register handed to decode via valid/ready.
module fetch_stage #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] RESET_PC   = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rd,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_pc_plus4,
  output logic [31:0]           fetch_count
);

  logic [31:0] pc;
  logic        load;

  // Redirect targets are byte addresses; only whole words are fetched.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential PC step; wraps naturally at 2**32.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  // Upper PC bits are dropped so fetches wrap within the memory depth.
  assign imem_addr = pc[ADDR_WIDTH+1:2];

  // Output register can take a new word when empty or being drained.
  assign load = !out_valid || out_ready;

  // PC, output register and handshake counter; redirect outranks a load,
  // but a handshake completing in the redirect cycle is still counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= 32'd0;
      out_pc       <= 32'd0;
      out_pc_plus4 <= 32'd0;
      fetch_count  <= 32'd0;
    end else begin
      if (out_valid && out_ready) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect) begin
        pc        <= word_align(redirect_pc);
        out_valid <= 1'b0;
      end else if (load) begin
        out_instr    <= imem_rd;
        out_pc       <= pc;
        out_pc_plus4 <= next_word(pc);
        out_valid    <= 1'b1;
        pc           <= next_word(pc);
      end
    end
  end

endmodule
